vx_mem_latency_stub: RTL and testbench

VX_MEM_LATENCY_STUB -- requirements
Module: vx_mem_latency_stub

---
 rtl/vx_mem_latency_stub.sv | 140 ++++++++++++++
 tb/tb_vx_mem_latency_stub.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_latency_stub.sv
// ============================================================================
// Module      : vx_mem_latency_stub
// Description : Multi-port memory model with private backing store per port
//               and a fixed, back-pressurable read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vx_mem_latency_stub #(
    parameter int NUM_PORTS      = 1,
    parameter int DATA_WIDTH     = 512,
    parameter int ADDR_WIDTH     = 26,
    parameter int TAG_WIDTH      = 8,
    parameter int LATENCY        = 4,
    parameter int QUEUE_DEPTH    = 4,
    parameter int MEM_LINES_LOG2 = 6
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_rw,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_PORTS*TAG_WIDTH-1:0]  req_tag,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [NUM_PORTS-1:0]            rsp_valid,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_data,
    output logic [NUM_PORTS*TAG_WIDTH-1:0]  rsp_tag,
    input  logic [NUM_PORTS-1:0]            rsp_ready,
    output logic                            pending,
    output logic [NUM_PORTS*16-1:0]         rd_count,
    output logic [NUM_PORTS*16-1:0]         wr_count
);

    localparam int c_ptr_w = $clog2(QUEUE_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_lines = 1 << MEM_LINES_LOG2;

    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(QUEUE_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [3:0]         c_lat     = 4'(LATENCY);

    logic [NUM_PORTS-1:0] w_busy;

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_port
            logic [DATA_WIDTH-1:0]     r_mem    [c_lines];
            logic [DATA_WIDTH-1:0]     r_q_data [QUEUE_DEPTH];
            logic [TAG_WIDTH-1:0]      r_q_tag  [QUEUE_DEPTH];
            logic [3:0]                r_q_age  [QUEUE_DEPTH];
            logic [c_ptr_w-1:0]        r_wr_ptr;
            logic [c_ptr_w-1:0]        r_rd_ptr;
            logic [c_cnt_w-1:0]        r_count;
            logic [15:0]               r_rd_cnt;
            logic [15:0]               r_wr_cnt;
            logic                      w_ready;
            logic                      w_push;
            logic                      w_write;
            logic                      w_pop;
            logic                      w_head_vld;
            logic [MEM_LINES_LOG2-1:0] w_idx;

            assign w_idx      = req_addr[p*ADDR_WIDTH +: MEM_LINES_LOG2];
            assign w_ready    = (r_count < c_depth);
            assign w_head_vld = (r_count != '0) && (r_q_age[r_rd_ptr] == c_lat);
            // Nothing is accepted while reset is held, so the store stays untouched.
            assign w_push     = reset & req_valid[p] & w_ready & ~req_rw[p];
            assign w_write    = reset & req_valid[p] & w_ready &  req_rw[p];
            assign w_pop      = w_head_vld & rsp_ready[p];

            if (ADDR_WIDTH > MEM_LINES_LOG2) begin : g_addr_hi
                logic w_unused_addr;
                assign w_unused_addr =
                    ^req_addr[p*ADDR_WIDTH+MEM_LINES_LOG2 +: ADDR_WIDTH-MEM_LINES_LOG2];
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                    r_rd_cnt <= '0;
                    r_wr_cnt <= '0;
                    for (int i = 0; i < QUEUE_DEPTH; i++) begin
                        r_q_age[i] <= '0;
                    end
                end else begin
                    // Free slots age too; a push always restarts its slot at zero.
                    for (int i = 0; i < QUEUE_DEPTH; i++) begin
                        if (r_q_age[i] != c_lat) begin
                            r_q_age[i] <= r_q_age[i] + 4'd1;
                        end
                    end
                    if (w_push) begin
                        r_q_age[r_wr_ptr] <= '0;
                        r_wr_ptr          <= r_wr_ptr + c_ptr_one;
                        r_rd_cnt          <= r_rd_cnt + 16'd1;
                    end
                    if (w_write) begin
                        r_wr_cnt <= r_wr_cnt + 16'd1;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= r_rd_ptr + c_ptr_one;
                    end
                    if (w_push && !w_pop) begin
                        r_count <= r_count + c_cnt_one;
                    end else if (!w_push && w_pop) begin
                        r_count <= r_count - c_cnt_one;
                    end
                end
            end

            // Storage without reset; read capture sees the line as of this edge.
            always_ff @(posedge clk) begin
                if (w_write) begin
                    r_mem[w_idx] <= req_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
                if (w_push) begin
                    r_q_data[r_wr_ptr] <= r_mem[w_idx];
                    r_q_tag[r_wr_ptr]  <= req_tag[p*TAG_WIDTH +: TAG_WIDTH];
                end
            end

            assign req_ready[p]                       = w_ready;
            assign rsp_valid[p]                       = w_head_vld;
            assign rsp_data[p*DATA_WIDTH +: DATA_WIDTH] = w_head_vld ? r_q_data[r_rd_ptr] : '0;
            assign rsp_tag[p*TAG_WIDTH +: TAG_WIDTH]    = w_head_vld ? r_q_tag[r_rd_ptr]  : '0;
            assign rd_count[p*16 +: 16]               = r_rd_cnt;
            assign wr_count[p*16 +: 16]               = r_wr_cnt;
            assign w_busy[p]                          = (r_count != '0);
        end
    endgenerate

    assign pending = |w_busy;

endmodule

`default_nettype wire

// File: tb/tb_vx_mem_latency_stub.sv
// Testbench for vx_mem_latency_stub: two ports, queue-based reference model
// compared every cycle, plus directed cases with literal expectations.
`default_nettype none

module tb_vx_mem_latency_stub;

    localparam int NP  = 2;
    localparam int DW  = 32;
    localparam int AW  = 8;
    localparam int TW  = 8;
    localparam int LAT = 4;
    localparam int QD  = 4;
    localparam int ML  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP-1:0]    req_valid;
    logic [NP-1:0]    req_rw;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_data;
    logic [NP*TW-1:0] req_tag;
    logic [NP-1:0]    req_ready;
    logic [NP-1:0]    rsp_valid;
    logic [NP*DW-1:0] rsp_data;
    logic [NP*TW-1:0] rsp_tag;
    logic [NP-1:0]    rsp_ready;
    logic             pending;
    logic [NP*16-1:0] rd_count;
    logic [NP*16-1:0] wr_count;

    vx_mem_latency_stub #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .LATENCY(LAT), .QUEUE_DEPTH(QD), .MEM_LINES_LOG2(ML)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .rsp_ready(rsp_ready), .pending(pending),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int p, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s port%0d: got %h expected %h at %0t", name, p, act, exp, $time);
        end
    endtask

    // Reference model: a queue of outstanding reads per port, each stamped
    // with the edge it was accepted on; it is visible once LAT edges old.
    typedef struct {
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        int unsigned   a;
    } ent_t;

    ent_t          mq [NP][$];
    logic [DW-1:0] m_mem [NP][1<<ML];
    logic [15:0]   m_rd [NP];
    logic [15:0]   m_wr [NP];
    int unsigned   edge_n = 0;
    bit            m_rdy [NP];
    bit            m_pop [NP];

    function automatic bit m_valid(int p);
        return (mq[p].size() != 0) && ((edge_n - mq[p][0].a) >= LAT);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NP; p++) begin
                mq[p].delete();
                m_rd[p] = '0;
                m_wr[p] = '0;
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                m_rdy[p] = mq[p].size() < QD;
                m_pop[p] = m_valid(p) && rsp_ready[p];
            end
            edge_n++;
            for (int p = 0; p < NP; p++) begin
                logic [ML-1:0] idx;
                idx = req_addr[p*AW +: ML];
                if (m_pop[p]) void'(mq[p].pop_front());
                if (req_valid[p] && m_rdy[p]) begin
                    if (req_rw[p]) begin
                        m_mem[p][idx] = req_data[p*DW +: DW];
                        m_wr[p]++;
                    end else begin
                        mq[p].push_back('{d: m_mem[p][idx], t: req_tag[p*TW +: TW], a: edge_n});
                        m_rd[p]++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            bit ev;
            ev = m_valid(p);
            chk("req_ready", p, 32'(req_ready[p]), 32'(mq[p].size() < QD));
            chk("rsp_valid", p, 32'(rsp_valid[p]), 32'(ev));
            chk("rsp_data",  p, rsp_data[p*DW +: DW], ev ? mq[p][0].d : '0);
            chk("rsp_tag",   p, 32'(rsp_tag[p*TW +: TW]), ev ? 32'(mq[p][0].t) : 32'h0);
            chk("rd_count",  p, 32'(rd_count[p*16 +: 16]), 32'(m_rd[p]));
            chk("wr_count",  p, 32'(wr_count[p*16 +: 16]), 32'(m_wr[p]));
        end
        chk("pending", 0, 32'(pending), 32'((mq[0].size() != 0) || (mq[1].size() != 0)));
    end

    task automatic set_req(input int p, input logic v, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [TW-1:0] t);
        req_valid[p]          = v;
        req_rw[p]             = rw;
        req_addr[p*AW +: AW]  = a;
        req_data[p*DW +: DW]  = d;
        req_tag[p*TW +: TW]   = t;
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = '0;
        req_rw    = '0;
        req_addr  = '0;
        req_data  = '0;
        req_tag   = '0;
        rsp_ready = '0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        // Write then read of line 5, latency exactly LAT.
        set_req(0, 1'b1, 1'b1, 8'h05, 32'hA5A5A5A5, 8'h00);
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 8'h05, 32'h0, 8'h3C);
        rsp_ready = 2'b11;
        @(negedge clk);
        req_valid = '0;
        for (int k = 0; k < LAT; k++) begin
            chk("lat_early_valid", 0, 32'(rsp_valid[0]), 32'h0);
            @(negedge clk);
        end
        chk("lat_valid", 0, 32'(rsp_valid[0]), 32'h1);
        chk("lat_data",  0, rsp_data[DW-1:0], 32'hA5A5A5A5);
        chk("lat_tag",   0, 32'(rsp_tag[TW-1:0]), 32'h3C);
        chk("lat_wr",    0, 32'(wr_count[15:0]), 32'd1);
        chk("lat_rd",    0, 32'(rd_count[15:0]), 32'd1);

        // Known pattern in every line of both ports.
        for (int i = 0; i < (1 << ML); i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++)
                set_req(p, 1'b1, 1'b1, 8'(i), 32'hD0000000 | 32'(p << 8) | 32'(i), 8'h0);
        end
        @(negedge clk);
        req_valid = '0;

        // Fill with back-pressure, stall a fifth request, then drain in order.
        rsp_ready[0] = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            set_req(0, 1'b1, 1'b0, 8'(t), 32'h0, 8'(t));
            @(negedge clk);
        end
        chk("full_ready", 0, 32'(req_ready[0]), 32'h0);
        chk("full_rd",    0, 32'(rd_count[15:0]), 32'd5);
        set_req(0, 1'b1, 1'b0, 8'h09, 32'h0, 8'h05);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", 0, 32'(req_ready[0]), 32'h0);
            chk("stall_rd",    0, 32'(rd_count[15:0]), 32'd5);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            chk("drain_valid", 0, 32'(rsp_valid[0]), 32'h1);
            chk("drain_tag",   0, 32'(rsp_tag[TW-1:0]), 32'(t));
            @(negedge clk);
        end
        chk("drain_pending", 0, 32'(pending), 32'h0);

        // Full queue, request held, back-pressure released.
        rsp_ready[0] = 1'b0;
        for (int t = 0; t < 4; t++) begin
            set_req(0, 1'b1, 1'b0, 8'(t), 32'h0, 8'(8'h10 + t));
            @(negedge clk);
        end
        set_req(0, 1'b1, 1'b0, 8'h07, 32'h0, 8'h20);
        repeat (5) @(negedge clk);
        chk("bp_ready", 0, 32'(req_ready[0]), 32'h0);
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("pop1_ready", 0, 32'(req_ready[0]), 32'h1);
        chk("pop1_valid", 0, 32'(rsp_valid[0]), 32'h1);
        chk("pop1_rd",    0, 32'(rd_count[15:0]), 32'd9);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("stream_rd",    0, 32'(rd_count[15:0]), 32'(9 + k));
            chk("stream_ready", 0, 32'(req_ready[0]), 32'h1);
            if (k < 3) chk("stream_valid", 0, 32'(rsp_valid[0]), 32'h1);
        end
        req_valid[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Port 1 stalled full while port 0 reads; upper address bits ignored.
        rsp_ready = 2'b01;
        for (int t = 0; t < 4; t++) begin
            set_req(1, 1'b1, 1'b0, 8'(t), 32'h0, 8'(8'hE0 + t));
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h13, 32'h0, 8'h77);
        @(negedge clk);
        req_valid[0] = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            chk("iso_early_valid", 0, 32'(rsp_valid[0]), 32'h0);
            @(negedge clk);
        end
        chk("iso_valid", 0, 32'(rsp_valid[0]), 32'h1);
        chk("iso_data",  0, rsp_data[DW-1:0], 32'hD0000003);
        chk("iso_tag",   0, 32'(rsp_tag[TW-1:0]), 32'h77);
        chk("iso_valid", 1, 32'(rsp_valid[1]), 32'h1);
        chk("iso_data",  1, rsp_data[DW +: DW], 32'hD0000100);
        chk("iso_tag",   1, 32'(rsp_tag[TW +: TW]), 32'hE0);

        // Randomized traffic; port 1 stays back-pressured for the first part.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++)
                set_req(p, 1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 3) == 0),
                        8'($urandom), 32'($urandom), 8'($urandom));
            rsp_ready[0] = 1'($urandom_range(0, 3) != 0);
            rsp_ready[1] = (c < 600) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = 2'b11;
        repeat (20) @(negedge clk);

        // Reset with reads in flight.
        for (int t = 0; t < 3; t++) begin
            set_req(0, 1'b1, 1'b0, 8'(t), 32'h0, 8'(8'h31 + t));
            @(negedge clk);
        end
        req_valid = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_ready",   0, 32'(req_ready), 32'h3);
        chk("rst_valid",   0, 32'(rsp_valid), 32'h0);
        chk("rst_pending", 0, 32'(pending), 32'h0);
        chk("rst_tag",     0, 32'(rsp_tag), 32'h0);
        chk("rst_rd",      0, rd_count, 32'h0);
        chk("rst_wr",      0, wr_count, 32'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("post_rst_valid",   0, 32'(rsp_valid), 32'h0);
            chk("post_rst_pending", 0, 32'(pending), 32'h0);
        end

        // Write counter wrap.
        for (int i = 0; i < 65536; i++) begin
            set_req(0, 1'b1, 1'b1, 8'(i), 32'(i), 8'h0);
            if (i == 65535) chk("wr_pre_wrap", 0, 32'(wr_count[15:0]), 32'hFFFF);
            @(negedge clk);
        end
        req_valid = '0;
        chk("wr_wrap", 0, 32'(wr_count[15:0]), 32'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
